// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for CPU pipeline stage registers.
// Holds the default payload width and the skid-stage occupancy encoding.
package cpu_pipe_pkg;

  localparam int unsigned PIPE_WIDTH = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/dffn_en.sv
// WIDTH-bit data register with write enable and synchronous active-low reset.
// The register holds its value on any cycle without a write.
module dffn_en #(
  parameter int unsigned       WIDTH   = cpu_pipe_pkg::PIPE_WIDTH,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wen_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  // NOTE: reset is tested inside the posedge block, so it is synchronous.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_o <= RST_VAL;
    end else if (wen_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake, flush and optional skid entry.
// SKID=1 gives a flop-driven in_ready; SKID=0 is a single entry with combinational in_ready.
module pipe_skid_reg
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH   = PIPE_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter bit               SKID    = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             m_valid_q, m_valid_d;
  logic             s_valid_q, s_valid_d;
  logic             m_wen, s_wen, m_from_skid;
  logic [WIDTH-1:0] m_din, m_data_q, s_data_q;
  logic             accept, issue;
  skid_state_e      state;

  assign accept    = in_valid & in_ready;
  assign issue     = m_valid_q & out_ready;
  assign out_valid = m_valid_q;
  assign out_data  = m_data_q;
  assign state     = s_valid_q ? FULL : (m_valid_q ? BUSY : EMPTY);
  assign m_din     = m_from_skid ? s_data_q : in_data;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    m_valid_d   = m_valid_q;
    s_valid_d   = s_valid_q;
    m_wen       = 1'b0;
    s_wen       = 1'b0;
    m_from_skid = 1'b0;
    if (SKID) begin
      case (state)
        EMPTY: begin
          if (accept) begin
            m_wen     = 1'b1;
            m_valid_d = 1'b1;
          end
        end
        BUSY: begin
          if (accept && issue) begin
            m_wen = 1'b1;
          end else if (accept) begin
            s_wen     = 1'b1;
            s_valid_d = 1'b1;
          end else if (issue) begin
            m_valid_d = 1'b0;
          end
        end
        FULL: begin
          if (issue) begin
            m_wen       = 1'b1;
            m_from_skid = 1'b1;
            s_valid_d   = 1'b0;
          end
        end
        default: ;
      endcase
    end else begin
      if (accept) begin
        m_wen     = 1'b1;
        m_valid_d = 1'b1;
      end else if (issue) begin
        m_valid_d = 1'b0;
      end
    end
    // Squash discards the beat accepted this cycle and leaves data untouched.
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
      m_wen     = 1'b0;
      s_wen     = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
    end else begin
      m_valid_q <= m_valid_d;
    end
  end

  dffn_en #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .wen_i (m_wen),
    .d_i   (m_din),
    .q_o   (m_data_q)
  );

  generate
    if (SKID) begin : g_skid
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          s_valid_q <= 1'b0;
        end else begin
          s_valid_q <= s_valid_d;
        end
      end

      dffn_en #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .wen_i (s_wen),
        .d_i   (in_data),
        .q_o   (s_data_q)
      );

      assign in_ready = rst_n & ~s_valid_q;
    end else begin : g_noskid
      assign s_valid_q = 1'b0;
      assign s_data_q  = RST_VAL;
      assign in_ready  = rst_n & (~m_valid_q | out_ready);
    end
  endgenerate

endmodule
